// File: rtl/mul_seq_mac.sv
// mul_seq_mac -- iterative shift-add multiplier with optional accumulation.
//
// One WIDTH x WIDTH product per operation (signed or unsigned), computed over
// WIDTH shift-add cycles, then either loaded into or added onto an ACC_WIDTH
// accumulator. A sticky flag records any accumulator overflow.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, sampled only when idle
//   in1, in2     multiplicand / multiplier, captured with start
//   signed_mode  1 = two's-complement operands, captured with start
//   acc_en       1 = accumulate, 0 = load, captured with start
//   acc_clr      clears out and overflow, honoured only when idle
//   out          accumulator value
//   done         one-cycle pulse, out holds the new result
//   busy         operation in flight
//   overflow     sticky accumulator overflow
module mul_seq_mac #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 sign_r;
  logic                 smode_r;
  logic                 accen_r;

  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 ovf_s, ovf_hit;

  // Two's-complement negation of the most-negative value yields 2^(WIDTH-1)
  // when read as unsigned, so the magnitude fits in WIDTH bits.
  always_comb begin
    mag1 = in1;
    mag2 = in2;
    if (signed_mode && in1[WIDTH-1]) mag1 = ~in1 + WIDTH'(1);
    if (signed_mode && in2[WIDTH-1]) mag2 = ~in2 + WIDTH'(1);
  end

  always_comb begin
    prod_fix = sign_r ? (~prod + (2*WIDTH)'(1)) : prod;
    ext      = smode_r ? ACC_WIDTH'($signed(prod_fix)) : ACC_WIDTH'(prod_fix);
    sum_w    = {1'b0, out} + {1'b0, ext};
    ovf_s    = (out[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
               (sum_w[ACC_WIDTH-1] != out[ACC_WIDTH-1]);
    ovf_hit  = smode_r ? ovf_s : sum_w[ACC_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy and done are registered off the state, so each trails the state
  // register by one cycle: busy rises the cycle after acceptance and done
  // pulses the cycle after the DONE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      smode_r  <= 1'b0;
      accen_r  <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          // Clear lands now; the accumulate of a simultaneous start happens
          // at FIX, so it naturally builds on the cleared value.
          if (acc_clr) begin
            out      <= '0;
            overflow <= 1'b0;
          end
          if (start) begin
            mcand   <= (2*WIDTH)'(mag1);
            mplier  <= mag2;
            sign_r  <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            smode_r <= signed_mode;
            accen_r <= acc_en;
            prod    <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          if (accen_r) begin
            out <= sum_w[ACC_WIDTH-1:0];
            if (ovf_hit) overflow <= 1'b1;
          end else begin
            out <= ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_mac.sv
module tb_mul_seq_mac;

  localparam int W   = 16;
  localparam int AW  = 2*W+8;
  localparam int SW  = 4;
  localparam int SAW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, sm, ae, clr;
  logic [W-1:0]  in1, in2;
  logic [AW-1:0] out;
  logic          done, busy, ovf;

  logic           s_start, s_sm, s_ae, s_clr;
  logic [SW-1:0]  s_in1, s_in2;
  logic [SAW-1:0] s_out;
  logic           s_done, s_busy, s_ovf;

  mul_seq_mac #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .signed_mode(sm), .acc_en(ae), .acc_clr(clr),
    .out(out), .done(done), .busy(busy), .overflow(ovf)
  );

  mul_seq_mac #(.WIDTH(SW), .ACC_WIDTH(SAW)) sdut (
    .clk(clk), .reset(reset), .start(s_start), .in1(s_in1), .in2(s_in2),
    .signed_mode(s_sm), .acc_en(s_ae), .acc_clr(s_clr),
    .out(s_out), .done(s_done), .busy(s_busy), .overflow(s_ovf)
  );

  int checks = 0;
  int errors = 0;

  longint m_out = 0;
  bit     m_ovf = 1'b0;
  longint s_mout = 0;
  bit     s_movf = 1'b0;

  // Reference: true integer product, then accumulate with modular wrap and
  // overflow decided by whether the exact sum leaves the representable range.
  function automatic void model(input int w, input int accw, input longint a,
                                input longint b, input bit smd, input bit aen,
                                inout longint acc, inout bit ov);
    longint mask, half, sa, sb, p, pm, sacc, tot;
    mask = (longint'(1) << accw) - 1;
    half = longint'(1) << (accw-1);
    sa = a;
    sb = b;
    if (smd) begin
      if (a >= (longint'(1) << (w-1))) sa = a - (longint'(1) << w);
      if (b >= (longint'(1) << (w-1))) sb = b - (longint'(1) << w);
    end
    p  = sa * sb;
    pm = p & mask;
    if (!aen) acc = pm;
    else begin
      if (smd) begin
        sacc = (acc >= half) ? acc - (longint'(1) << accw) : acc;
        tot  = sacc + p;
        if (tot >= half || tot < -half) ov = 1'b1;
      end else if (acc + pm > mask) ov = 1'b1;
      acc = (acc + pm) & mask;
    end
  endfunction

  // Drives one operation on the selected DUT, scrambles its inputs while in
  // flight, and returns cycles from the accepting edge to the visible done.
  task automatic run_op(input bit sel, input longint a, input longint b,
                        input bit smd, input bit aen, input bit c,
                        output int lat);
    @(negedge clk);
    if (!sel) begin
      in1 = W'(a); in2 = W'(b); sm = smd; ae = aen; clr = c; start = 1'b1;
    end else begin
      s_in1 = SW'(a); s_in2 = SW'(b); s_sm = smd; s_ae = aen; s_clr = c; s_start = 1'b1;
    end
    @(posedge clk); #1;
    if (!sel) begin
      start = 1'b0; clr = 1'b0;
      in1 = W'($urandom); in2 = W'($urandom); sm = 1'($urandom); ae = 1'($urandom);
    end else begin
      s_start = 1'b0; s_clr = 1'b0;
      s_in1 = SW'($urandom); s_in2 = SW'($urandom); s_sm = 1'($urandom); s_ae = 1'($urandom);
    end
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if ((!sel && done) || (sel && s_done)) break;
    end
    if (!sel) begin
      if (c) begin m_out = 0; m_ovf = 1'b0; end
      model(W, AW, a, b, smd, aen, m_out, m_ovf);
    end else begin
      if (c) begin s_mout = 0; s_movf = 1'b0; end
      model(SW, SAW, a, b, smd, aen, s_mout, s_movf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 0; sm = 0; ae = 0; clr = 0; in1 = '0; in2 = '0;
    s_start = 0; s_sm = 0; s_ae = 0; s_clr = 0; s_in1 = '0; s_in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== '0 || done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%0h done=%b busy=%b ovf=%b expected all 0", out, done, busy, ovf);
    end
    checks++;
    if (s_out !== '0 || s_done !== 1'b0 || s_busy !== 1'b0 || s_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_small: got out=%0h done=%b busy=%b ovf=%b expected all 0", s_out, s_done, s_busy, s_ovf);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(0, 8648, 2301, 0, 0, 0, lat);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL unsigned_latency: got %0d expected 18", lat); end
    checks++;
    if (out !== AW'(19899048) || ovf !== 1'b0) begin
      errors++; $display("FAIL unsigned_out: got %0d ovf=%b expected 19899048 ovf=0", out, ovf);
    end
  endtask

  task automatic test_signed();
    int lat;
    run_op(0, 'hFFFD, 5, 1, 0, 0, lat);
    checks++;
    if (out !== 40'hFF_FFFF_FFF1) begin errors++; $display("FAIL signed_neg: got %0h expected fffffffff1", out); end
    run_op(0, 'h8000, 'h8000, 1, 0, 0, lat);
    checks++;
    if (out !== AW'(32'h4000_0000)) begin errors++; $display("FAIL signed_minmin: got %0h expected 40000000", out); end
  endtask

  task automatic test_accumulate();
    int lat;
    run_op(0, 8648, 2301, 0, 0, 0, lat);
    run_op(0, 8648, 2301, 0, 1, 0, lat);
    checks++;
    if (out !== AW'(39798096)) begin errors++; $display("FAIL acc_sum: got %0d expected 39798096", out); end
    run_op(0, 2, 3, 0, 1, 1, lat);
    checks++;
    if (out !== AW'(6)) begin errors++; $display("FAIL acc_clr_start: got %0d expected 6", out); end
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 24; i++) begin
      run_op(0, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), lat);
      checks++;
      if (lat !== 18 || out !== AW'(m_out) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_%0d: got out=%0h ovf=%b lat=%0d expected out=%0h ovf=%b lat=18", i, out, ovf, lat, m_out, m_ovf);
      end
    end
  endtask

  task automatic test_overflow_small();
    int lat;
    run_op(1, 15, 15, 0, 0, 0, lat);
    checks++;
    if (s_out !== 8'd225 || s_ovf !== 1'b0 || lat !== 6) begin
      errors++; $display("FAIL small_load: got %0d ovf=%b lat=%0d expected 225 ovf=0 lat=6", s_out, s_ovf, lat);
    end
    run_op(1, 15, 15, 0, 1, 0, lat);
    checks++;
    if (s_out !== 8'd194 || s_ovf !== 1'b1) begin
      errors++; $display("FAIL small_wrap: got %0d ovf=%b expected 194 ovf=1", s_out, s_ovf);
    end
    run_op(1, 1, 1, 0, 1, 0, lat);
    checks++;
    if (s_out !== 8'd195 || s_ovf !== 1'b1) begin
      errors++; $display("FAIL small_sticky: got %0d ovf=%b expected 195 ovf=1", s_out, s_ovf);
    end
    @(negedge clk); s_clr = 1'b1;
    @(negedge clk); s_clr = 1'b0;
    s_mout = 0; s_movf = 1'b0;
    checks++;
    if (s_out !== '0 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL small_clear: got %0d ovf=%b expected 0 ovf=0", s_out, s_ovf);
    end
    for (int i = 0; i < 16; i++) begin
      run_op(1, longint'($urandom_range(0, 15)), longint'($urandom_range(0, 15)),
             1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, lat);
      checks++;
      if (s_out !== SAW'(s_mout) || s_ovf !== s_movf) begin
        errors++;
        $display("FAIL small_random_%0d: got out=%0h ovf=%b expected out=%0h ovf=%b", i, s_out, s_ovf, s_mout, s_movf);
      end
    end
  endtask

  task automatic test_protocol();
    int cnt, prev, lat;
    bit gap_ok;
    // start held for three cycles
    @(negedge clk);
    in1 = 16'd1234; in2 = 16'd77; sm = 0; ae = 0; clr = 0; start = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 3) start = 1'b0;
      if (done) cnt++;
    end
    model(W, AW, 1234, 77, 0, 0, m_out, m_ovf);
    checks++;
    if (cnt !== 1 || out !== AW'(m_out)) begin
      errors++; $display("FAIL start_held3: got %0d pulses out=%0d expected 1 pulses out=%0d", cnt, out, m_out);
    end
    // start pulsed during CALC
    @(negedge clk);
    in1 = 16'd300; in2 = 16'd11; start = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 6) begin start = 1'b1; in1 = 16'd999; in2 = 16'd999; end
      if (c == 7) start = 1'b0;
      if (done) cnt++;
    end
    model(W, AW, 300, 11, 0, 0, m_out, m_ovf);
    checks++;
    if (cnt !== 1 || out !== AW'(m_out)) begin
      errors++; $display("FAIL start_in_calc: got %0d pulses out=%0d expected 1 pulses out=%0d", cnt, out, m_out);
    end
    // acc_clr during CALC has no effect
    run_op(0, 500, 40, 0, 0, 0, lat);
    @(negedge clk);
    in1 = 16'd500; in2 = 16'd40; ae = 1'b1; start = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 5) clr = 1'b1;
      if (c == 6) clr = 1'b0;
      if (done) cnt++;
    end
    model(W, AW, 500, 40, 0, 1, m_out, m_ovf);
    checks++;
    if (cnt !== 1 || out !== AW'(m_out)) begin
      errors++; $display("FAIL clr_in_calc: got %0d pulses out=%0d expected 1 pulses out=%0d", cnt, out, m_out);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, prev;
    bit gap_ok;
    @(negedge clk);
    in1 = 16'd4321; in2 = 16'd12; sm = 0; ae = 0; clr = 0; start = 1'b1;
    cnt = 0; prev = -1; gap_ok = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (prev >= 0 && (c - prev) != W+3) gap_ok = 1'b0;
        prev = c;
        cnt++;
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    model(W, AW, 4321, 12, 0, 0, m_out, m_ovf);
    checks++;
    if (cnt !== 4 || !gap_ok) begin
      errors++; $display("FAIL back_to_back: got %0d pulses spacing_ok=%b expected 4 pulses spacing %0d", cnt, gap_ok, W+3);
    end
    checks++;
    if (out !== AW'(m_out)) begin
      errors++; $display("FAIL back_to_back_out: got %0d expected %0d", out, m_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat, cnt;
    run_op(0, 1234, 4321, 0, 0, 0, lat);
    @(negedge clk);
    in1 = 16'd50; in2 = 16'd60; ae = 0; sm = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got out=%0h busy=%b done=%b ovf=%b expected all 0", out, busy, done, ovf);
    end
    m_out = 0; m_ovf = 1'b0; s_mout = 0; s_movf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL reset_abort: got %0d active cycles expected 0", cnt); end
    run_op(0, 7, 9, 0, 0, 0, lat);
    checks++;
    if (out !== AW'(63) || lat !== 18) begin
      errors++; $display("FAIL after_reset: got out=%0d lat=%0d expected 63 lat=18", out, lat);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_accumulate();
    test_random();
    test_overflow_small();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_mac.md
# mul_seq_mac

Parametrised iterative shift-add multiplier with optional accumulation and selectable signed/unsigned mode. It is the successor to the fixed 16-bit sequential multiplier in the CNN datapath. It computes one WIDTH×WIDTH product per operation over WIDTH+2 cycles, and either loads or accumulates the result into an ACC_WIDTH accumulator. It sits in the PE array as the MAC element between the operand buffers and the partial-sum writeback.

## Interface
- `WIDTH`, 16: operand width in bits; must be ≥ 2.
- `ACC_WIDTH`, 2*WIDTH+8: accumulator/result width; must be ≥ 2*WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `start` input 1: operation request; sampled only in IDLE.
- `in1` input WIDTH: multiplicand; captured when start is accepted.
- `in2` input WIDTH: multiplier; captured when start is accepted.
- `signed_mode` input 1: 1 = two's-complement operands, 0 = unsigned; captured with start.
- `acc_en` input 1: 1 = add product to accumulator, 0 = load product; captured with start.
- `acc_clr` input 1: clears accumulator and overflow; honoured only in IDLE.
- `out` output ACC_WIDTH: accumulator value; changes only at the FIX edge or on clear/reset.
- `done` output 1: one-cycle pulse; `out` is valid for the new result.
- `busy` output 1: high in CALC, FIX and DONE.
- `overflow` output 1: sticky accumulator overflow flag.

## Operation
- States: IDLE → CALC → FIX → DONE → IDLE.
- IDLE, start=1: latch in1, in2, signed_mode and acc_en. Load the magnitude registers:
  - signed_mode=1: |in1| and |in2| as unsigned WIDTH-bit values. The most-negative value maps to 2^(WIDTH-1), so no extra bit is needed.
  - Record the result sign as sign(in1) XOR sign(in2).
  - signed_mode=0: operands are used as-is and the sign is 0.
- Go to CALC and clear the 2*WIDTH partial product and the bit counter.
- CALC: each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the partial product. Then shift the multiplier right and the multiplicand left. Exit to FIX after exactly WIDTH cycles, when the counter reaches WIDTH-1.
- FIX:
  - Negate the product if the recorded sign is 1.
  - Extend the product to ACC_WIDTH: sign-extend if signed_mode, zero-extend otherwise.
  - acc_en=0: out ← product. acc_en=1: out ← out + product, wrapping modulo 2^ACC_WIDTH.
- overflow is set (never cleared here) when acc_en=1 and:
  - unsigned: the addition carries out of bit ACC_WIDTH-1.
  - signed: both addends have the same sign and the sum's sign differs.
- DONE: done=1 for exactly this cycle, then return to IDLE.
- acc_clr in IDLE: out←0 and overflow←0 at the next edge.
  - If start is also 1 in the same cycle, the clear applies first, so an acc_en=1 operation accumulates onto 0.
  - acc_clr is ignored outside IDLE.
- start while not IDLE is ignored. If start is held through DONE, a new operation is accepted on the first IDLE cycle. In-flight operands are never disturbed by input changes.

## Timing
- Reset values: out=0, done=0, busy=0, overflow=0, state=IDLE, all internal registers 0.
- Reset asserted mid-operation aborts immediately and asynchronously: no done pulse, out=0.
- Start accepted at edge k:
  - busy=1 from k+1.
  - CALC spans edges k+1 … k+WIDTH.
  - FIX updates out at edge k+WIDTH+1.
  - done=1 during the cycle after edge k+WIDTH+2.
  - busy=0 after edge k+WIDTH+3.
- Latency from start acceptance to the done pulse is WIDTH+2 cycles. Throughput is one operation per WIDTH+3 cycles.
- `out` is stable from the FIX edge until the next FIX, clear or reset.
- Zero operands still take the full WIDTH cycles; there is no early termination.

## Test plan
- Unsigned, default params: in1=8648, in2=2301, acc_en=0 → done 18 cycles after acceptance, out=19899048, overflow=0.
- Signed: in1=-3 (0xFFFD), in2=5, acc_en=0 → out=0xFF_FFFF_FFF1 (-15). Then in1=in2=0x8000 → out=0x40000000.
- Accumulate: the 8648×2301 op with acc_en=0, then the same op with acc_en=1 → out=39798096. Then acc_clr+start with acc_en=1, in1=2, in2=3 → out=6.
- Overflow, WIDTH=4, ACC_WIDTH=8, unsigned: 15×15 load → out=225. 15×15 accumulate → out=194, overflow=1. A 1×1 accumulate keeps overflow=1. acc_clr → out=0, overflow=0.
- Protocol: start held high for 3 cycles → exactly one done pulse. start pulsed during CALC → ignored. start held continuously → back-to-back ops with done spaced WIDTH+3 cycles apart. acc_clr during CALC → no effect.
- Reset: assert reset=0 mid-CALC → out, busy and done drop to 0 immediately. After release, a new 7×9 op gives out=63.
